// File: rtl/alu_uart_sequencer_if.sv
// Byte-level handshake between uart_rx/uart_tx, the combinational ALU and the sequencer.
// master: the sequencer side; slave: the surrounding top level (UARTs and ALU).
interface alu_uart_sequencer_if #(
    parameter int BITS = 8
);
    logic            rx_done;
    logic [7:0]      rx_data;
    logic            tx_done;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic [BITS-1:0] alu_a;
    logic [BITS-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [BITS-1:0] alu_result;
    logic            busy;
    logic            err;

    modport master (
        input  rx_done, rx_data, tx_done, alu_result,
        output tx_start, tx_data, alu_a, alu_b, alu_op, busy, err
    );

    modport slave (
        output rx_done, rx_data, tx_done, alu_result,
        input  tx_start, tx_data, alu_a, alu_b, alu_op, busy, err
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, OPCODE bytes from uart_rx, runs the ALU for one cycle and hands the result to uart_tx.
// Optional opcode validation is enabled by defining ALU_SEQ_OPCHECK_EN.
module alu_uart_sequencer #(
    parameter int BITS           = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    alu_uart_sequencer_if.master        bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        WAIT_OP,
        EXEC,
        WAIT_TX
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load_a;
    logic             load_b;
    logic             load_op;
    logic             err_d;
    logic             op_ok;
    logic             waiting;
    logic             timeout_hit;
    logic [CNT_W-1:0] tmo_cnt;

`ifdef ALU_SEQ_OPCHECK_EN
    function automatic logic opcode_valid(input logic [7:0] code);
        if (code[7:4] != 4'h0) begin
            return 1'b0;
        end
        case (code[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h9, 4'hB, 4'hC: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    assign op_ok = opcode_valid(bus.rx_data);
`else
    assign op_ok = 1'b1;
`endif

    // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle clock; a byte in that cycle still wins.
    assign waiting     = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && waiting &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign bus.busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_done) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.rx_done) begin
                    load_b  = 1'b1;
                    state_d = WAIT_OP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_OP: begin
                if (bus.rx_done) begin
                    if (op_ok) begin
                        load_op = 1'b1;
                        state_d = EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tmo_cnt      <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= 4'h0;
            bus.err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus.err      <= err_d;
            bus.tx_start <= (state_q == EXEC);

            if (!waiting || bus.rx_done || timeout_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (load_a) begin
                bus.alu_a <= BITS'(bus.rx_data);
            end
            if (load_b) begin
                bus.alu_b <= BITS'(bus.rx_data);
            end
            if (load_op) begin
                bus.alu_op <= bus.rx_data[3:0];
            end
            // ALU output has settled during the single EXEC cycle.
            if (state_q == EXEC) begin
                bus.tx_data <= bus.alu_result[7:0];
            end
        end
    end

endmodule
